// File: rtl/mips32_mem_dumper.sv
// mips32_mem_dumper: once the processor halts, reads a window of data memory
// word by word and presents each word on a valid/ready output stream.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for a rising edge on halted
//  READ   | one-cycle memory read strobe at cur_addr
//  WAIT   | memory returns data; capture word and its address
//  SEND   | present word, hold until the consumer accepts it
//  DONE   | dump complete; stay here until halted drops
module mips32_mem_dumper #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_R     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              halted_q;
  logic              halted_rise;
  logic              xfer;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   remaining;

  assign halted_rise = halted & ~halted_q;
  // an abort (halted low) wins over a handshake in the same cycle
  assign xfer        = (state == S_SEND) & dout_ready & halted;

  // state register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state and decoded outputs
  always_comb begin
    state_nxt  = state;
    mem_rd_en  = 1'b0;
    mem_addr   = mem_addr_q;
    dout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (halted_rise) state_nxt = (word_count == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = cur_addr;
        busy      = 1'b1;
        state_nxt = halted ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        busy      = 1'b1;
        state_nxt = halted ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        dout_valid = 1'b1;
        busy       = 1'b1;
        if (!halted)   state_nxt = S_IDLE;
        else if (xfer) state_nxt = (remaining == ONE_R) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done = 1'b1;
        if (!halted) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // halted sample, dump pointers and captured output word
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      cur_addr   <= '0;
      remaining  <= '0;
      mem_addr_q <= '0;
      dout_addr  <= '0;
      dout_data  <= '0;
    end else begin
      halted_q <= halted;
      if (state == S_IDLE && halted_rise) begin
        cur_addr  <= start_addr;
        remaining <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
      end
      if (state == S_READ) mem_addr_q <= cur_addr;
      if (state == S_WAIT) begin
        dout_data <= mem_rd_data;
        dout_addr <= cur_addr;
      end
      if (xfer) begin
        remaining <= remaining - ONE_R;
        cur_addr  <= cur_addr + ONE_A;
      end
    end
  end

endmodule

// File: tb/tb_mips32_mem_dumper.sv
// Directed bench for mips32_mem_dumper with a one-cycle-latency memory model.
module tb_mips32_mem_dumper;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        halted;
  logic [9:0]  start_addr;
  logic [10:0] word_count;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [9:0]  dout_addr;
  logic [31:0] dout_data;
  logic        busy;
  logic        done;

  logic [31:0] mem [1024];
  logic [9:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          rd_cnt    = 0;
  int          valid_cnt = 0;
  int          n_checks  = 0;
  int          n_err     = 0;

  mips32_mem_dumper #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .halted      (halted),
    .start_addr  (start_addr),
    .word_count  (word_count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_addr   (dout_addr),
    .dout_data   (dout_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk1 = ~clk1;

  // memory: data valid the cycle after the read strobe
  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // monitor: count strobes/valid cycles and log accepted words
  always @(negedge clk1) begin
    if (mem_rd_en) rd_cnt++;
    if (dout_valid) valid_cnt++;
    if (rst_n && dout_valid && dout_ready && halted) begin
      log_addr.push_back(dout_addr);
      log_data.push_back(dout_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      tick();
      i++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_dout_addr"}, dout_addr, 0);
    chk({tag, "_dout_data"}, dout_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int b, rd0, v0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'd7;
    mem[120]  = 32'd85;
    mem[121]  = 32'd130;
    mem[1023] = 32'hfc00_0000;
    mem[0]    = 32'h2801_0078;
    mem[5]    = 32'hdead_beef;

    rst_n = 1'b0; halted = 1'b0; start_addr = '0; word_count = '0; dout_ready = 1'b1;
    tick(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // two-word dump, stimulus changed after trigger must be ignored
    start_addr = 10'd120; word_count = 11'd2;
    rd0 = rd_cnt; b = log_addr.size();
    halted = 1'b1;
    tick();
    chk("t1_rd_en", mem_rd_en, 1);
    chk("t1_mem_addr0", mem_addr, 120);
    chk("t1_busy", busy, 1);
    start_addr = 10'd7; word_count = 11'd9;
    tick();
    chk("t1_rd_en_wait", mem_rd_en, 0);
    chk("t1_mem_addr_hold", mem_addr, 120);
    tick();
    chk("t1_valid0", dout_valid, 1);
    chk("t1_addr0", dout_addr, 120);
    chk("t1_data0", dout_data, 85);
    tick();
    chk("t1_valid_gap", dout_valid, 0);
    chk("t1_mem_addr1", mem_addr, 121);
    tick(2);
    chk("t1_addr1", dout_addr, 121);
    chk("t1_data1", dout_data, 130);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_nwords", log_addr.size() - b, 2);
    chk("t1_log_a0", log_addr[b], 120);
    chk("t1_log_d0", log_data[b], 85);
    chk("t1_log_a1", log_addr[b+1], 121);
    chk("t1_log_d1", log_data[b+1], 130);
    chk("t1_rd_pulses", rd_cnt - rd0, 2);
    halted = 1'b0;
    tick();
    chk("t1_done_clear", done, 0);

    // zero-length dump
    start_addr = 10'd50; word_count = 11'd0;
    rd0 = rd_cnt; v0 = valid_cnt;
    halted = 1'b1;
    tick();
    chk("t2_done", done, 1);
    tick(3);
    chk("t2_done_hold", done, 1);
    chk("t2_no_rd", rd_cnt - rd0, 0);
    chk("t2_no_valid", valid_cnt - v0, 0);
    halted = 1'b0;
    tick();

    // address wrap 1023 -> 0
    start_addr = 10'd1023; word_count = 11'd2;
    b = log_addr.size();
    halted = 1'b1;
    tick();
    start_addr = 10'd0; word_count = 11'd0;
    wait_done(20);
    chk("t3_nwords", log_addr.size() - b, 2);
    chk("t3_a0", log_addr[b], 1023);
    chk("t3_d0", log_data[b], 32'hfc00_0000);
    chk("t3_a1", log_addr[b+1], 0);
    chk("t3_d1", log_data[b+1], 32'h2801_0078);
    halted = 1'b0;
    tick();

    // backpressure: word held stable while ready is low
    start_addr = 10'd5; word_count = 11'd1; dout_ready = 1'b0;
    b = log_addr.size();
    halted = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_hold", dout_valid, 1);
      chk("t4_addr_hold", dout_addr, 5);
      chk("t4_data_hold", dout_data, 32'hdead_beef);
      tick();
    end
    chk("t4_none_yet", log_addr.size() - b, 0);
    dout_ready = 1'b1;
    tick();
    chk("t4_done", done, 1);
    chk("t4_nwords", log_addr.size() - b, 1);
    chk("t4_log_d", log_data[b], 32'hdead_beef);
    halted = 1'b0;
    tick();

    // reset during SEND of word 1 of 3, halted held high through release
    start_addr = 10'd200; word_count = 11'd3;
    halted = 1'b1;
    tick(3);
    chk("t5_in_send", dout_valid, 1);
    start_addr = 10'd300;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t5_async");
    tick();
    rst_n = 1'b1;
    b = log_addr.size();
    wait_done(30);
    chk("t5_nwords", log_addr.size() - b, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_addr", log_addr[b+i], 300 + i);
      chk("t5_data", log_data[b+i], 32'h1000_0000 + 32'(300 + i) * 32'd7);
    end
    halted = 1'b0;
    tick();

    // abort in WAIT of word 2 of 4, then a fresh full dump
    start_addr = 10'd400; word_count = 11'd4;
    b = log_addr.size(); rd0 = rd_cnt;
    halted = 1'b1;
    tick(5);
    chk("t6_in_wait_busy", busy, 1);
    halted = 1'b0;
    tick();
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_done", done, 0);
    chk("t6_abort_valid", dout_valid, 0);
    tick(2);
    chk("t6_partial", log_addr.size() - b, 1);
    chk("t6_rd_partial", rd_cnt - rd0, 2);
    b = log_addr.size();
    halted = 1'b1;
    wait_done(40);
    chk("t6_nwords", log_addr.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_addr", log_addr[b+i], 400 + i);
      chk("t6_data", log_data[b+i], 32'h1000_0000 + 32'(400 + i) * 32'd7);
    end
    halted = 1'b0;
    tick();

    // oversize count clamps to 1024 words and wraps the address
    start_addr = 10'd10; word_count = 11'd1500;
    b = log_addr.size(); rd0 = rd_cnt;
    halted = 1'b1;
    wait_done(3200);
    chk("t7_nwords", log_addr.size() - b, 1024);
    chk("t7_rd_pulses", rd_cnt - rd0, 1024);
    chk("t7_first", log_addr[b], 10);
    chk("t7_last", log_addr[b+1023], 9);
    halted = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
